// File: rtl/game_master_multishot_fsm.sv
// Game master: sequences target/torpedo sprites over rounds of N_SHOTS, keeps a saturating score and match win.
// Latency: all outputs are registered Moore decodes of the state entered on each edge.
// Backpressure: ROUND_WON/ROUND_LOST hold while the end-of-game timer runs. GAME_MASTER_LIVES_EN adds lives/game over.
module game_master_multishot_fsm #(
  parameter int N_SHOTS   = 3,
  parameter int SHOT_W    = 2,
  parameter int WIN_SCORE = 10,
  parameter int SCORE_W   = 4,
  parameter int LIVES     = 3,
  parameter int LIFE_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  output logic               sprite_target_write_xy,
  output logic               sprite_torpedo_write_xy,
  output logic               sprite_target_write_dxy,
  output logic               sprite_torpedo_write_dxy,
  output logic               sprite_target_enable_update,
  output logic               sprite_torpedo_enable_update,
  input  logic               sprite_target_within_screen,
  input  logic               sprite_torpedo_within_screen,
  input  logic               collision,
  output logic               end_of_game_timer_start,
  input  logic               end_of_game_timer_running,
  output logic               game_won,
  output logic               match_won,
  output logic [SHOT_W-1:0]  shots_left,
  output logic [SCORE_W-1:0] score,
  output logic [LIFE_W-1:0]  lives,
  output logic               game_over
);

  typedef enum logic [8:0] {
    S_START_TARGET    = 9'h001,
    S_WAIT_KEY        = 9'h002,
    S_START_TORPEDO   = 9'h004,
    S_WAIT_COLLISION  = 9'h008,
    S_RELOAD          = 9'h010,
    S_START_END_TIMER = 9'h020,
    S_ROUND_WON       = 9'h040,
    S_ROUND_LOST      = 9'h080,
    S_GAME_OVER       = 9'h100
  } state_t;

  localparam logic [SHOT_W-1:0]  SHOTS_INIT = SHOT_W'(N_SHOTS);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);

  state_t              state;
  state_t              state_nxt;
  logic                key_prev;
  logic                collision_reg;
  logic                key_rise;
  logic                tgt_out;
  logic                trp_out;
  logic [SHOT_W-1:0]   shots_nxt;
  logic [SCORE_W-1:0]  score_nxt;
`ifdef GAME_MASTER_LIVES_EN
  logic [LIFE_W-1:0]   lives_nxt;
`else
  // Without the lives feature the game never ends: lives is a constant and GAME_OVER is unreachable.
  assign lives     = LIVES_INIT;
  assign game_over = 1'b0;
`endif

  assign key_rise = key & ~key_prev;
  assign tgt_out  = ~sprite_target_within_screen;
  assign trp_out  = ~sprite_torpedo_within_screen;

  // Next-state and counter updates; illegal (zero / multi-hot) vectors fall back to START_TARGET.
  always_comb begin
    state_nxt = S_START_TARGET;
    shots_nxt = shots_left;
    score_nxt = score;
`ifdef GAME_MASTER_LIVES_EN
    lives_nxt = lives;
`endif
    case (state)
      S_START_TARGET: begin
        state_nxt = S_WAIT_KEY;
        shots_nxt = SHOTS_INIT;
      end
      S_WAIT_KEY: begin
        if (tgt_out || collision) begin
          state_nxt = S_START_END_TIMER;
        end else if (key_rise && shots_left != '0) begin
          state_nxt = S_START_TORPEDO;
          shots_nxt = shots_left - 1'b1;
        end else begin
          state_nxt = S_WAIT_KEY;
        end
      end
      S_START_TORPEDO: state_nxt = S_WAIT_COLLISION;
      S_WAIT_COLLISION: begin
        if (collision || tgt_out)                  state_nxt = S_START_END_TIMER;
        else if (trp_out && shots_left != '0)      state_nxt = S_RELOAD;
        else if (trp_out)                          state_nxt = S_START_END_TIMER;
        else                                       state_nxt = S_WAIT_COLLISION;
      end
      S_RELOAD: state_nxt = S_WAIT_KEY;
      S_START_END_TIMER: begin
        // collision_reg lines up with the collision that ended the round one cycle earlier
        if (collision_reg) begin
          state_nxt = S_ROUND_WON;
          if (score != SCORE_MAX) score_nxt = score + 1'b1;
        end else begin
          state_nxt = S_ROUND_LOST;
`ifdef GAME_MASTER_LIVES_EN
          if (lives != '0) lives_nxt = lives - 1'b1;
`endif
        end
      end
      S_ROUND_WON: begin
        if (end_of_game_timer_running) begin
          state_nxt = S_ROUND_WON;
        end else begin
          state_nxt = S_START_TARGET;
          if (score == SCORE_WIN) score_nxt = '0;
        end
      end
      S_ROUND_LOST: begin
        if (end_of_game_timer_running) begin
          state_nxt = S_ROUND_LOST;
        end else begin
`ifdef GAME_MASTER_LIVES_EN
          state_nxt = (lives == '0) ? S_GAME_OVER : S_START_TARGET;
`else
          state_nxt = S_START_TARGET;
`endif
        end
      end
      S_GAME_OVER: begin
`ifdef GAME_MASTER_LIVES_EN
        if (key_rise) begin
          state_nxt = S_START_TARGET;
          lives_nxt = LIVES_INIT;
          score_nxt = '0;
        end else begin
          state_nxt = S_GAME_OVER;
        end
`else
        state_nxt = S_START_TARGET;
`endif
      end
      default: state_nxt = S_START_TARGET;
    endcase
  end

  // State, counters and Moore outputs registered together so outputs track the state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= state_t'(9'd0);
      key_prev                     <= 1'b1;
      collision_reg                <= 1'b0;
      shots_left                   <= '0;
      score                        <= '0;
      sprite_target_write_xy       <= 1'b0;
      sprite_torpedo_write_xy      <= 1'b0;
      sprite_target_write_dxy      <= 1'b0;
      sprite_torpedo_write_dxy     <= 1'b0;
      sprite_target_enable_update  <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start      <= 1'b0;
      game_won                     <= 1'b0;
      match_won                    <= 1'b0;
`ifdef GAME_MASTER_LIVES_EN
      lives                        <= LIVES_INIT;
      game_over                    <= 1'b0;
`endif
    end else begin
      state                        <= state_nxt;
      key_prev                     <= key;
      collision_reg                <= collision;
      shots_left                   <= shots_nxt;
      score                        <= score_nxt;
      sprite_target_write_xy       <= (state_nxt == S_START_TARGET);
      sprite_torpedo_write_xy      <= (state_nxt == S_START_TARGET) || (state_nxt == S_RELOAD);
      sprite_target_write_dxy      <= (state_nxt == S_START_TARGET);
      sprite_torpedo_write_dxy     <= (state_nxt == S_WAIT_KEY) || (state_nxt == S_WAIT_COLLISION);
      sprite_target_enable_update  <= (state_nxt == S_WAIT_KEY) || (state_nxt == S_START_TORPEDO) ||
                                      (state_nxt == S_WAIT_COLLISION) || (state_nxt == S_RELOAD);
      sprite_torpedo_enable_update <= (state_nxt == S_WAIT_COLLISION);
      end_of_game_timer_start      <= (state_nxt == S_START_END_TIMER);
      game_won                     <= (state_nxt == S_ROUND_WON);
      match_won                    <= (state_nxt == S_ROUND_WON) && (score_nxt == SCORE_WIN);
`ifdef GAME_MASTER_LIVES_EN
      lives                        <= lives_nxt;
      game_over                    <= (state_nxt == S_GAME_OVER);
`endif
    end
  end

endmodule
